// File: rtl/mmio_out_if.sv
// Bus bundle between the CPU memory stage and the MMIO output port.
// master: CPU side (drives the address/store/load strobes and the consumer ready); slave: mmio_out.
interface mmio_out_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] dm_rdata;
   logic        dm_we;
   logic [31:0] rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   modport master (
      output addr, wdata, mem_write, mem_read, dm_rdata, out_ready,
      input  dm_we, rdata, out_valid, out_data
   );

   modport slave (
      input  addr, wdata, mem_write, mem_read, dm_rdata, out_ready,
      output dm_we, rdata, out_valid, out_data
   );
endinterface

// File: rtl/mmio_out.sv
// MMIO output port: a 16-byte window (DATA/STATUS/CLEAR) fronting a DEPTH-entry output FIFO.
// Optional drop counter is built only when MMIO_DROP_CNT_EN is defined.
module mmio_out #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
) (
   input logic        clk,
   input logic        reset,
   mmio_out_if.slave  bus
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

   if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
      $error("mmio_out: DEPTH must be 2, 4 or 8");
   end

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] head, tail, head_n;
   logic [3:0]    count, count_n;
   logic          out_valid_q;
   logic [31:0]   out_data_q;
   logic          hit, full, empty, data_wr, push, pop;
   logic [3:0]    off;
   logic [15:0]   drop_cnt;
   logic [31:0]   status;

   assign hit     = (bus.addr[31:4] == MMIO_BASE[31:4]);
   assign off     = bus.addr[3:0];
   assign data_wr = bus.mem_write & hit & (off == 4'h0);
   assign full    = (count == DEPTH_C);
   assign empty   = (count == 4'd0);
   assign pop     = out_valid_q & bus.out_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts the store.
   assign push    = data_wr & (~full | pop);
   assign head_n  = pop ? head + AW'(1) : head;

   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + 4'd1;
         2'b01:   count_n = count - 4'd1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= bus.wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         head        <= head_n;
         if (push) tail <= tail + AW'(1);
         count       <= count_n;
         out_valid_q <= (count_n != 4'd0);
         // Preload the next head word; it is the incoming store when it lands at the new head.
         if (count_n == 4'd0)
            out_data_q <= '0;
         else if (push && (tail == head_n))
            out_data_q <= bus.wdata;
         else
            out_data_q <= mem[head_n];
      end
   end

`ifdef MMIO_DROP_CNT_EN
   logic clr_wr, drop;
   assign clr_wr = bus.mem_write & hit & (off == 4'h8);
   assign drop   = data_wr & full & ~pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         drop_cnt <= '0;
      else if (clr_wr)
         drop_cnt <= '0;
      else if (drop && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign drop_cnt = '0;
`endif

   assign status = {drop_cnt, 6'b0, full, empty, 4'b0, count};

   always_comb begin
      bus.rdata = '0;
      if (!hit)
         bus.rdata = bus.dm_rdata;
      else if (bus.mem_read && (off == 4'h4))
         bus.rdata = status;
   end

   assign bus.dm_we     = bus.mem_write & ~hit;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mmio_out.sv
// Scoreboard bench for mmio_out: accepted DATA stores are queued and compared as the FIFO drains.
module tb_mmio_out;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_7F00;

   logic clk;
   logic reset;
   mmio_out_if bus();

   mmio_out #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] sb[$];
   logic [15:0] m_drop = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [15:0] d;
`ifdef MMIO_DROP_CNT_EN
      d = m_drop;
`else
      d = '0;
`endif
      return {d, 6'b0, (sb.size() == DEPTH), (sb.size() == 0), 4'b0, 4'(sb.size())};
   endfunction

   task automatic set_bus(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic rdy);
      bus.mem_write = we;
      bus.mem_read  = re;
      bus.addr      = a;
      bus.wdata     = d;
      bus.out_ready = rdy;
   endtask

   // Called just after a negedge with inputs stable; checks outputs, advances the model, clocks once.
   task automatic tick();
      logic        pop, dw, full;
      logic [31:0] exp;
      #1;
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, (sb.size() != 0)});
      pop  = (sb.size() != 0) && bus.out_ready;
      dw   = bus.mem_write && (bus.addr == BASE);
      full = (sb.size() == DEPTH);
      if (pop) begin
         exp = sb.pop_front();
         check("pop_data", bus.out_data, exp);
      end else begin
         check("head_data", bus.out_data, (sb.size() != 0) ? sb[0] : 32'h0);
      end
      if (dw) begin
         if (!full || pop) sb.push_back(bus.wdata);
         else if (m_drop != 16'hFFFF) m_drop++;
      end
      if (bus.mem_write && (bus.addr == BASE + 32'h8)) m_drop = '0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_status(input string tag);
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b1;
      bus.addr      = BASE + 32'h4;
      #1;
      check(tag, bus.rdata, exp_status());
      bus.mem_read  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         set_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
         tick();
      end
      check("drain_empty", 32'(sb.size()), 32'h0);
      set_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b0;
      bus.dm_rdata = 32'hCAFE_F00D;
      set_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
      check("rst_data", bus.out_data, 32'h0);
      check_status("rst_status");
      reset = 1'b1;

      // Single store into DATA, consumer stalled.
      set_bus(1'b1, 1'b0, BASE, 32'h1234_5678, 1'b0);
      #1 check("dm_we_hit", {31'b0, bus.dm_we}, 32'h0);
      tick();
      check("one_valid", {31'b0, bus.out_valid}, 32'h1);
      check("one_data", bus.out_data, 32'h1234_5678);
      check_status("one_status");
      check("one_status_k", bus.rdata, 32'h0000_0001);
      drain();

      // Ordinary memory traffic passes through untouched.
      set_bus(1'b1, 1'b0, 32'h0000_0010, 32'h0000_00AA, 1'b0);
      #1 check("dm_we_miss", {31'b0, bus.dm_we}, 32'h1);
      tick();
      set_bus(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1'b0);
      #1 check("load_miss", bus.rdata, 32'hCAFE_F00D);
      tick();
      check_status("miss_status");

      // Unused offsets read zero and ignore writes; reads need mem_read.
      set_bus(1'b0, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
      #1 check("no_read_zero", bus.rdata, 32'h0);
      set_bus(1'b0, 1'b1, BASE, 32'h0, 1'b0);
      #1 check("data_read_zero", bus.rdata, 32'h0);
      set_bus(1'b0, 1'b1, BASE + 32'hC, 32'h0, 1'b0);
      #1 check("off_c_read", bus.rdata, 32'h0);
      set_bus(1'b1, 1'b0, BASE + 32'hC, 32'h55, 1'b0);
      tick();
      set_bus(1'b1, 1'b0, BASE + 32'h1, 32'h66, 1'b0);
      tick();
      check_status("ignored_writes");

      // Overflow: six stores into a four-entry FIFO.
      for (int i = 1; i <= 6; i++) begin
         set_bus(1'b1, 1'b0, BASE, 32'(i), 1'b0);
         tick();
      end
      check_status("overflow_status");
`ifdef MMIO_DROP_CNT_EN
      check("overflow_k", bus.rdata, 32'h0002_0204);
`else
      check("overflow_k", bus.rdata, 32'h0000_0204);
`endif
      // Store while full and popping: accepted, drop count unchanged.
      set_bus(1'b1, 1'b0, BASE, 32'h9, 1'b1);
      tick();
      check_status("full_pushpop");
      // Clear the drop counter.
      set_bus(1'b1, 1'b0, BASE + 32'h8, 32'hDEAD, 1'b0);
      tick();
      check_status("clear_status");
      drain();

      // Random mix of stores, clears, status reads and memory traffic.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] d;
         logic        rdy;
         d   = $urandom;
         rdy = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0, 1, 2: set_bus(1'b1, 1'b0, BASE, d, rdy);
            3:       set_bus(1'b1, 1'b0, BASE + 32'h8, d, rdy);
            4:       begin
                        check_status("rand_status");
                        set_bus(1'b0, 1'b0, 32'h0, 32'h0, rdy);
                     end
            default: set_bus(1'b1, 1'b0, 32'h0000_0100, d, rdy);
         endcase
         tick();
      end
      drain();

      // Asynchronous reset with three words queued.
      for (int i = 0; i < 3; i++) begin
         set_bus(1'b1, 1'b0, BASE, 32'hA0 + 32'(i), 1'b0);
         tick();
      end
      set_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("async_valid", {31'b0, bus.out_valid}, 32'h0);
      check("async_data", bus.out_data, 32'h0);
      sb.delete();
      m_drop = '0;
      @(negedge clk);
      reset = 1'b1;
      check_status("post_rst_status");
      // First push right after reset release.
      set_bus(1'b1, 1'b0, BASE, 32'h7777_0001, 1'b1);
      tick();
      set_bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
